// File: rtl/tpu_pkg.sv
// Shared constants for the Wishbone systolic matrix unit:
// register offsets, CTRL/STATUS bit positions, FSM codes, defaults.
package tpu_pkg;

    localparam logic [31:0] DEF_BASE = 32'h3000_0000;
    localparam int DEF_N  = 3;
    localparam int DEF_DW = 8;
    localparam int DEF_AW = 16;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_WEIGHT = 2'd1;
    localparam logic [1:0] OFF_INPUT  = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_SOFT_CLR = 1;
    localparam int CTRL_SIGNED   = 2;

    localparam int STAT_ERR    = 3;
    localparam int STAT_SIGNED = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/pe_array.sv
// Output-stationary N x N multiply-accumulate grid; X flows right,
// W flows down, PE(i,j) owns C[i][j].
module pe_array #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [N*DW-1:0]   a_in,
    input  logic [N*DW-1:0]   b_in,
    input  logic              en,
    input  logic              clr,
    input  logic              sgn,
    output logic [N*N*AW-1:0] acc
);

    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] v,
                                          input logic s);
        logic [AW-1:0] r;
        r = (s && v[DW-1]) ? '1 : '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            logic [DW-1:0] a_r;
            logic [DW-1:0] b_r;
            logic [AW-1:0] acc_r;

            if (j == 0) begin : g_al
                assign a = a_in[i*DW +: DW];
            end else begin : g_an
                assign a = a_q[i][j-1];
            end

            if (i == 0) begin : g_bt
                assign b = b_in[j*DW +: DW];
            end else begin : g_bn
                assign b = b_q[i-1][j];
            end

            // low AW bits of the product are exact for both signednesses
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    acc_r <= '0;
                end else if (clr) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    acc_r <= '0;
                end else if (en) begin
                    a_r   <= a;
                    b_r   <= b;
                    acc_r <= acc_r + ext(a, sgn) * ext(b, sgn);
                end
            end

            assign a_q[i][j] = a_r;
            assign b_q[i][j] = b_r;
            assign acc[(i*N+j)*AW +: AW] = acc_r;
        end
    end

endmodule

// File: rtl/wb_systolic_tpu.sv
// Wishbone slave wrapping a systolic matrix multiplier: bus decode,
// sequencing FSM, operand buffers and result readout.
module wb_systolic_tpu
    import tpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = DEF_BASE,
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o
);

    localparam int EPW = 32 / DW;
    localparam int NN  = N * N;
    localparam int IW  = $clog2(NN);
    localparam int PW  = $clog2(NN + 1);
    localparam int RW  = $clog2(N + 1);
    localparam int CW  = $clog2(3 * N);
    localparam logic [CW-1:0] RUN_LAST = CW'(3 * N - 3);

    state_t state, nxt;

    logic [1:0]    rst_sync;
    logic          ready;
    logic [1:0]    off;
    logic          access, wr, rd;
    logic          ctrl_wr, soft_clr, ctrl_set, start_req;
    logic          w_ok, w_done, x_ok, start_ok, ctrl_ok, rd_ok, last_rd;
    logic          bad, run_en;
    logic          err, signed_q;
    logic [DW-1:0] w_buf [NN];
    logic [DW-1:0] x_buf [NN];
    logic [PW-1:0] w_ptr, rd_ptr;
    logic [RW-1:0] x_row;
    logic [CW-1:0] run_cnt;
    logic [N*DW-1:0]   a_in, b_in;
    logic [N*N*AW-1:0] acc;
    logic [AW-1:0]     res;
    logic [31:0]       res32, rdata;
    logic              unused;

    assign unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

    // bus stays deaf until reset release has passed two edges
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign ready = rst_sync[1];

    assign off    = wb_adr_i[3:2];
    assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o & ready &
                    (wb_adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign wr     = access & wb_we_i;
    assign rd     = access & ~wb_we_i;

    assign ctrl_wr   = wr & (off == OFF_CTRL);
    assign soft_clr  = ctrl_wr & wb_dat_i[CTRL_SOFT_CLR];
    assign ctrl_set  = ctrl_wr & ~soft_clr;
    assign start_req = ctrl_set & wb_dat_i[CTRL_START];

    assign w_ok = wr & (off == OFF_WEIGHT) &
                  (state == ST_IDLE || state == ST_LOAD_W);
    assign w_done = w_ok && (int'(w_ptr) + EPW >= NN);
    assign x_ok = wr & (off == OFF_INPUT) &
                  (state == ST_LOAD_X) & (x_row != RW'(N));
    assign start_ok = start_req & (state == ST_LOAD_X) &
                      (x_row == RW'(N));
    assign ctrl_ok = ctrl_set & (start_req ? start_ok : state != ST_RUN);
    assign rd_ok   = rd & (off == OFF_RESULT) & (state == ST_DONE);
    assign last_rd = rd_ok & (rd_ptr == PW'(NN - 1));

    assign bad = (wr & (off == OFF_WEIGHT) & ~w_ok) |
                 (wr & (off == OFF_INPUT) & ~x_ok) |
                 (ctrl_set & ~ctrl_ok) |
                 (wr & (off == OFF_RESULT)) |
                 (rd & (off == OFF_RESULT) & ~rd_ok);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (soft_clr) begin
            nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (w_ok) nxt = w_done ? ST_LOAD_X : ST_LOAD_W;
                ST_LOAD_W: if (w_done) nxt = ST_LOAD_X;
                ST_LOAD_X: if (start_ok) nxt = ST_RUN;
                ST_RUN:    if (run_cnt == RUN_LAST) nxt = ST_DONE;
                ST_DONE:   if (last_rd) nxt = ST_IDLE;
                default:   nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run_en = (state == ST_RUN);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) begin
                w_buf[k] <= '0;
                x_buf[k] <= '0;
            end
            w_ptr    <= '0;
            x_row    <= '0;
            rd_ptr   <= '0;
            run_cnt  <= '0;
            err      <= 1'b0;
            signed_q <= 1'b0;
        end else if (soft_clr) begin
            for (int k = 0; k < NN; k++) begin
                w_buf[k] <= '0;
                x_buf[k] <= '0;
            end
            w_ptr    <= '0;
            x_row    <= '0;
            rd_ptr   <= '0;
            run_cnt  <= '0;
            err      <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            if (bad) err <= 1'b1;
            if (ctrl_ok) signed_q <= wb_dat_i[CTRL_SIGNED];
            if (w_ok) begin
                for (int k = 0; k < EPW; k++) begin
                    if (int'(w_ptr) + k < NN)
                        w_buf[IW'(int'(w_ptr) + k)] <= wb_dat_i[k*DW +: DW];
                end
                w_ptr <= w_done ? PW'(NN) : w_ptr + PW'(EPW);
            end
            if (x_ok) begin
                for (int c = 0; c < N; c++)
                    x_buf[IW'(int'(x_row) * N + c)] <= wb_dat_i[c*DW +: DW];
                x_row <= x_row + 1'b1;
            end
            if (start_ok)    run_cnt <= '0;
            else if (run_en) run_cnt <= run_cnt + 1'b1;
            if (rd_ok) begin
                rd_ptr <= last_rd ? '0 : rd_ptr + 1'b1;
                if (last_rd) begin
                    w_ptr <= '0;
                    x_row <= '0;
                end
            end
        end
    end

    // row i of X and column j of W enter i resp. j cycles late
    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(run_cnt) - i;
            if (run_en && k >= 0 && k < N) begin
                a_in[i*DW +: DW] = x_buf[IW'(i * N + k)];
                b_in[i*DW +: DW] = w_buf[IW'(k * N + i)];
            end
        end
    end

    pe_array #(
        .N (N),
        .DW(DW),
        .AW(AW)
    ) u_array (
        .clock(clock),
        .rst_n(rst_n),
        .a_in (a_in),
        .b_in (b_in),
        .en   (run_en),
        .clr  (soft_clr | start_ok),
        .sgn  (signed_q),
        .acc  (acc)
    );

    always_comb begin
        res = '0;
        for (int k = 0; k < NN; k++)
            if (int'(rd_ptr) == k) res = acc[k*AW +: AW];
        res32 = (signed_q && res[AW-1]) ? '1 : '0;
        res32[AW-1:0] = res;
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            OFF_CTRL: begin
                rdata[2:0]         = state;
                rdata[STAT_ERR]    = err;
                rdata[STAT_SIGNED] = signed_q;
            end
            OFF_RESULT: if (state == ST_DONE) rdata = res32;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= rd ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_wb_systolic_tpu.sv
// Directed bench for wb_systolic_tpu: sequencing, arithmetic corners,
// error handling, reset behaviour and ack spacing.
module tb_wb_systolic_tpu;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_W    = BASE + 32'h4;
    localparam logic [31:0] A_X    = BASE + 32'h8;
    localparam logic [31:0] A_RES  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_w = '0;
    logic [31:0] adr = '0;
    logic        ack;
    logic [31:0] dat_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_systolic_tpu #(
        .BASE_ADDRESS(BASE),
        .N (3),
        .DW(8),
        .AW(16)
    ) dut (
        .clock   (clk),
        .rst_n   (rst_n),
        .wb_stb_i(stb),
        .wb_cyc_i(cyc),
        .wb_we_i (we),
        .wb_sel_i(sel),
        .wb_dat_i(dat_w),
        .wb_adr_i(adr),
        .wb_ack_o(ack),
        .wb_dat_o(dat_r)
    );

    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] r);
        logic ok;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d;
        ok = 1'b0;
        r = '0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                ok = 1'b1;
                r = dat_r;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; dat_w = '0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bus_ack adr=%h: ack=0 after 8 cycles, required 1", a);
        end
    endtask

    task automatic load(input logic [31:0] w0, w1, w2, x0, x1, x2);
        logic [31:0] r;
        bus(1, A_W, w0, r);
        bus(1, A_W, w1, r);
        bus(1, A_W, w2, r);
        bus(1, A_X, x0, r);
        bus(1, A_X, x1, r);
        bus(1, A_X, x2, r);
    endtask

    task automatic test_reset;
        logic seen;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_CTRL;
        #1;
        n_tests++;
        if (ack !== 1'b0 || dat_r !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out ack=%b dat=%h, required 0/0", ack, dat_r);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sync_ack ack=%b in first cycle, required 0", ack);
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (ack) begin
                seen = 1'b1;
                n_tests++;
                if (dat_r !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_status got %h, required 0", dat_r);
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        stb = 1'b0; cyc = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_release_ack ack never seen, required 1");
        end
    endtask

    task automatic test_identity;
        logic [31:0] r;
        bus(1, A_CTRL, 32'h0, r);
        bus(1, A_W, 32'h0000_0001, r);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h1) begin
            n_fail++;
            $display("FAIL id_load_w status=%h, required 1", r);
        end
        bus(1, A_W, 32'h0000_0001, r);
        bus(1, A_W, 32'h0000_0001, r);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h2) begin
            n_fail++;
            $display("FAIL id_load_x status=%h, required 2", r);
        end
        bus(1, A_X, 32'h0003_0201, r);
        bus(1, A_X, 32'h0006_0504, r);
        bus(1, A_X, 32'h0009_0807, r);
        bus(1, A_CTRL, 32'h1, r);
        repeat (6) @(posedge clk);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h3) begin
            n_fail++;
            $display("FAIL id_run_7th status=%h, required 3", r);
        end
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h4) begin
            n_fail++;
            $display("FAIL id_done status=%h, required 4", r);
        end
        for (int k = 0; k < 9; k++) begin
            bus(0, A_RES, 32'h0, r);
            n_tests++;
            if (r !== 32'(k + 1)) begin
                n_fail++;
                $display("FAIL id_result[%0d] got %h, required %h", k, r, k + 1);
            end
        end
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL id_idle status=%h, required 0", r);
        end
    endtask

    task automatic test_signed;
        logic [31:0] r;
        bus(1, A_CTRL, 32'h4, r);
        load('1, '1, '1, 32'h0001_0101, 32'h0001_0101, 32'h0001_0101);
        bus(1, A_CTRL, 32'h5, r);
        repeat (7) @(posedge clk);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h14) begin
            n_fail++;
            $display("FAIL sg_done_8th status=%h, required 14", r);
        end
        for (int k = 0; k < 9; k++) begin
            bus(0, A_RES, 32'h0, r);
            n_tests++;
            if (r !== 32'hFFFF_FFFD) begin
                n_fail++;
                $display("FAIL sg_result[%0d] got %h, required fffffffd", k, r);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] r;
        bus(1, A_CTRL, 32'h0, r);
        load('1, '1, '1, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF);
        bus(1, A_CTRL, 32'h1, r);
        repeat (7) @(posedge clk);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h4) begin
            n_fail++;
            $display("FAIL wr_done status=%h, required 4", r);
        end
        for (int k = 0; k < 9; k++) begin
            bus(0, A_RES, 32'h0, r);
            n_tests++;
            if (r !== 32'h0000_FA03) begin
                n_fail++;
                $display("FAIL wr_result[%0d] got %h, required 0000fa03", k, r);
            end
        end
    endtask

    task automatic test_error;
        logic [31:0] r;
        bus(1, A_CTRL, 32'h1, r);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h8) begin
            n_fail++;
            $display("FAIL er_start_idle status=%h, required 8", r);
        end
        bus(1, A_CTRL, 32'h2, r);
        load(32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h3);
        bus(0, A_RES, 32'h0, r);
        n_tests++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL er_res_data got %h, required 0", r);
        end
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'hA) begin
            n_fail++;
            $display("FAIL er_status status=%h, required a", r);
        end
        bus(1, A_CTRL, 32'h7, r);
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL er_soft_clr status=%h, required 0", r);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] r;
        logic [31:0] exp_c [9];
        exp_c = '{32'd1, 32'd4, 32'd9, 32'd4, 32'd13, 32'd18,
                  32'd7, 32'd22, 32'd27};
        load(32'h1, 32'h1, 32'h1, 32'h0003_0201, 32'h0006_0504, 32'h0009_0807);
        bus(1, A_CTRL, 32'h1, r);
        repeat (2) @(posedge clk);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_CTRL;
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        n_tests++;
        if (ack !== 1'b1 || dat_r !== 32'h3) begin
            n_fail++;
            $display("FAIL rm_run_status ack=%b dat=%h, required 1/3", ack, dat_r);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ack !== 1'b0 || dat_r !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_reset_out ack=%b dat=%h, required 0/0", ack, dat_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_after_status status=%h, required 0", r);
        end
        bus(0, A_RES, 32'h0, r);
        bus(1, A_CTRL, 32'h2, r);
        load(32'h0000_0201, 32'h0000_0001, 32'h0000_0003,
             32'h0003_0201, 32'h0006_0504, 32'h0009_0807);
        bus(1, A_CTRL, 32'h1, r);
        repeat (7) @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            bus(0, A_RES, 32'h0, r);
            n_tests++;
            if (r !== exp_c[k]) begin
                n_fail++;
                $display("FAIL rm_result[%0d] got %h, required %h", k, r, exp_c[k]);
            end
        end
        bus(0, A_CTRL, 32'h0, r);
        n_tests++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_idle status=%h, required 0", r);
        end
    endtask

    task automatic test_back_to_back;
        repeat (2) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_CTRL;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (ack !== 1'(i % 2)) begin
                n_fail++;
                $display("FAIL b2b_ack[%0d] got %b, required %0d", i, ack, i % 2);
            end
            @(negedge clk);
        end
        adr = BASE + 32'h10;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ack !== 1'b0) begin
                n_fail++;
                $display("FAIL oow_ack[%0d] got %b, required 0", i, ack);
            end
            @(negedge clk);
        end
        stb = 1'b0; cyc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_wrap();
        test_error();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
